sram_stream_ctrl: RTL
=====================

# sram_stream_ctrl

Burst controller that acts as the initiator side of the 384x128 single-port SRAM wrapper interface. It accepts burst commands and then does one of two things: it writes an incoming valid/ready data stream into consecutive SRAM words, or it reads consecutive words out to a valid/ready output stream. Because the SRAM has one cycle of read latency, output backpressure is absorbed by a 2-entry output FIFO. The block sits between the datapath stream logic and the SRAM wrapper, and is the only master of the SRAM port.

## Interface
- DEPTH, 384: number of SRAM words; addresses wrap from DEPTH-1 to 0.
- WIDTH, 128: data width in bits.
- ADDR_BITS, 9: address width.
- clk  in  1  sole clock; everything sampled on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE; reset 0.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_BITS  start word address, must be < DEPTH.
- cmd_len  in  ADDR_BITS  number of words minus 1 (0..DEPTH-1).
- in_valid / in_ready  in / out  1  write-data handshake; in_ready reset 0.
- in_data  in  WIDTH  write data.
- out_valid / out_ready  out / in  1  read-data handshake; out_valid reset 0.
- out_data  out  WIDTH  read data; reset 0.
- done  out  1  one-cycle pulse when a burst completes; reset 0.
- mem_csb, mem_web  out  1  SRAM chip select and write enable, active-low; reset 1.
- mem_addr  out  ADDR_BITS  SRAM address; reset 0.
- mem_din  out  WIDTH  SRAM write data (combinational from in_data).
- mem_dout  in  WIDTH  SRAM read data, valid the cycle after a read is issued.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid the block loads addr = cmd_addr and remaining = cmd_len, then goes to WRITE or READ.
- WRITE:
  - in_ready=1.
  - Each in_valid&in_ready cycle drives mem_csb=0, mem_web=0, mem_addr=addr, mem_din=in_data.
  - On the word with remaining==0, the block pulses done and returns to IDLE. Otherwise addr advances (with wrap) and remaining decrements.
- READ:
  - A read is issued (mem_csb=0, mem_web=1) when fifo_count + inflight - pop < 2. Here pop = out_valid&out_ready, and inflight is a 1-bit flag for a read issued in the previous cycle.
  - A cycle with an inflight read pushes mem_dout into the FIFO.
  - After the last read is issued, the state moves to DRAIN.
- DRAIN: no SRAM access. Once inflight=0 and the FIFO is empty after the final pop, the block pulses done in the same cycle as that final pop and returns to IDLE.
- When not accessing, mem_csb=1 and mem_web=1. mem_web is never 0 while mem_csb=1.
- Address wrap: an increment from DEPTH-1 yields 0. No error is raised.
- FIFO: 2 entries, so it cannot overflow by construction. Push and pop in the same cycle keeps the count. out_data is the head entry.
- Reset, asserted at any time including mid-burst, immediately:
  - returns the block to IDLE;
  - clears the FIFO and inflight;
  - forces mem_csb=1 and mem_web=1.
  - The aborted burst gets no done pulse.

## Timing
- A command is accepted in cycle 0. The first SRAM access can occur in cycle 1.
- Write burst with in_valid held high: one word per cycle, in cycles 1..N. done is asserted in cycle N, with the last write.
- Read: issued in cycle t, mem_dout captured at the end of t+1, out_valid high in t+2.
  - With out_ready held high: one word per cycle, the first at cycle 3 after acceptance.
  - done coincides with the last out handshake.
- out_ready held low: at most 2 reads are outstanding (FIFO plus inflight). Issue resumes in the cycle a pop frees space.
- cmd_ready stays 0 from the acceptance cycle until the cycle after done.

## Structure
- Package sram_stream_pkg holds:
  - the state enum (IDLE/WRITE/READ/DRAIN);
  - the DEPTH, WIDTH and ADDR_BITS defaults;
  - a next_addr wrap function.
- Sub-module sram_stream_fifo2: a 2-entry synchronous FIFO with push/pop/count/head and the same reset. It is instantiated once for the read path.
- Sized for 150-250 lines of RTL in total.

## Test plan
- Write burst: cmd_write=1, addr=5, len=3, in_data 0xA0..0xA3 back-to-back -> four writes at addrs 5..8 in cycles 1..4; done in cycle 4.
- Read burst: addr=5, len=3, out_ready=1 -> out_data 0xA0..0xA3 in consecutive cycles starting cycle 3; done with the last.
- Read backpressure: len=7, out_ready toggling 1/0 and then low for 5 cycles -> no more than 2 words outstanding; all 8 words delivered in order with no loss or duplication.
- Wrap-around: write addr=382, len=3 -> writes land at 382, 383, 0, 1; a read burst at addr=382 returns the same data.
- in_valid gaps: write len=2 with in_valid low for 3 cycles mid-burst -> mem_csb=1 during the gap; done only on the third accepted word.
- Reset mid-read: rst_n=0 during the 3rd word -> mem_csb/out_valid/done/cmd_ready go to their reset values immediately; after release cmd_ready=1 and a new burst runs correctly.

Source files
------------

// File: rtl/sram_stream_pkg.sv
// Shared types and defaults for the SRAM burst stream controller.
// Holds the controller state encoding and the word-address wrap helper.
package sram_stream_pkg;

    localparam int unsigned SRAM_DEPTH     = 384;
    localparam int unsigned SRAM_WIDTH     = 128;
    localparam int unsigned SRAM_ADDR_BITS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Next word address; the top word wraps back to 0 without any error.
    function automatic int unsigned next_addr(input int unsigned a, input int unsigned depth);
        return (a == depth - 1) ? 0 : a + 1;
    endfunction

endpackage

// File: rtl/sram_stream_fifo2.sv
// Two-entry synchronous FIFO used to absorb output backpressure on the read path.
// The caller guarantees no push when full and no pop when empty.
module sram_stream_fifo2 #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/sram_stream_ctrl.sv
// Burst initiator for the single-port SRAM wrapper: streams write data into
// consecutive words, or reads consecutive words out through a 2-entry FIFO.
module sram_stream_ctrl
    import sram_stream_pkg::*;
#(
    parameter int unsigned DEPTH     = SRAM_DEPTH,
    parameter int unsigned WIDTH     = SRAM_WIDTH,
    parameter int unsigned ADDR_BITS = SRAM_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS-1:0] cmd_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 done,
    output logic                 mem_csb,
    output logic                 mem_web,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_din,
    input  logic [WIDTH-1:0]     mem_dout
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] r_remaining;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic                 r_inflight;
    logic                 r_cmd_ready;

    logic                 w_cmd_fire;
    logic                 w_wr_fire;
    logic                 w_rd_issue;
    logic                 w_pop;
    logic                 w_last;
    logic                 w_wr_done;
    logic                 w_drain_done;
    logic [1:0]           w_fifo_count;
    logic [2:0]           w_occupancy;
    logic [WIDTH-1:0]     w_fifo_head;

    assign w_addr_nxt = ADDR_BITS'(next_addr(32'(r_addr), DEPTH));
    assign w_last     = (r_remaining == '0);

    assign w_cmd_fire = r_cmd_ready && cmd_valid;
    assign w_wr_fire  = (r_state == ST_WRITE) && in_valid;
    assign w_pop      = out_valid && out_ready;

    // Reads in the FIFO plus the one in flight must stay within two entries,
    // counting the slot freed by a pop in this same cycle.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_rd_issue  = (r_state == ST_READ) && (w_occupancy < (3'd2 + {2'b00, w_pop}));

    assign w_wr_done    = w_wr_fire && w_last;
    assign w_drain_done = (r_state == ST_DRAIN) && !r_inflight && (w_fifo_count == 2'd1) && w_pop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_cmd_fire)              w_state_nxt = cmd_write ? ST_WRITE : ST_READ;
            ST_WRITE: if (w_wr_done)               w_state_nxt = ST_IDLE;
            ST_READ:  if (w_rd_issue && w_last)    w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done)            w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // cmd_ready is registered so it reads 0 while reset is held and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_inflight  <= w_rd_issue;
            if (w_cmd_fire) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if ((w_wr_fire || w_rd_issue) && !w_last) begin
                r_addr      <= w_addr_nxt;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    sram_stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (mem_dout),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_head      (w_fifo_head)
    );

    assign cmd_ready = r_cmd_ready;
    assign in_ready  = (r_state == ST_WRITE);
    assign out_valid = (w_fifo_count != 2'd0);
    assign out_data  = w_fifo_head;
    assign done      = w_wr_done || w_drain_done;

    assign mem_csb  = !(w_wr_fire || w_rd_issue);
    assign mem_web  = !w_wr_fire;
    assign mem_addr = r_addr;
    assign mem_din  = in_data;

endmodule
